cache_arbiter: RTL and testbench
================================

# cache_arbiter

Two-master arbiter sharing the single CPU-side port of the 4-way set-associative cache between the instruction fetch unit (`pc`) and the load/store data path. It accepts Avalon-style read/write commands from both requesters, grants one at a time, forwards the winner's command to the cache, and routes the cache's wait/valid responses back to the owner until the transaction completes. It sits between `pc`/LSU and `cache`, replacing the direct `pc`→`cache` connection.

## Interface
- `ADDR_W`, 25: cache word-address width (`CacheAddrBus`).
- `DATA_W`, 32: data width (`CacheDataBus`).
- `BE_W`, 4: byte-enable width (`CacheByteBus`).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_i_addr`, `i_i_read`  in  ADDR_W/1  instruction port command (read-only).
- `o_i_readdata`, `o_i_readdata_valid`, `o_i_waitrequest`  out  DATA_W/1/1  instruction port response.
- `i_d_addr`, `i_d_byte_en`, `i_d_writedata`, `i_d_read`, `i_d_write`  in  ADDR_W/BE_W/DATA_W/1/1  data port command.
- `o_d_readdata`, `o_d_readdata_valid`, `o_d_waitrequest`  out  DATA_W/1/1  data port response.
- `o_p_addr`, `o_p_byte_en`, `o_p_writedata`, `o_p_read`, `o_p_write`  out  ADDR_W/BE_W/DATA_W/1/1  command to cache.
- `i_p_readdata`, `i_p_readdata_valid`, `i_p_waitrequest`  in  DATA_W/1/1  cache response.
- `o_busy`  out  1  transaction in flight (state ≠ IDLE).
- `cnt_grant_i`, `cnt_grant_d`  out  32/32  grants issued per port, wrap at 2^32.

## Operation
- States: IDLE, GNT_I, GNT_D, RD_I, RD_D.
- IDLE: if any request (`i_i_read`, `i_d_read|i_d_write`) pending, select winner, go GNT_x next edge; increment that port's grant counter same edge.
- Arbitration without macro: data port wins when both request.
- GNT_x: cache command = owner's command (instruction port: byte_en all ones, writedata 0, write 0); other port's fields ignored. Stay while `i_p_waitrequest`=1.
- GNT_x, waitrequest=0: write → IDLE; read with `i_p_readdata_valid`=1 same cycle → IDLE; read otherwise → RD_x.
- RD_x: cache command deasserted (read=write=0); on `i_p_readdata_valid` → IDLE.
- Requester withdrawing command while in GNT_x (illegal) → arbiter returns to IDLE, no response routed.
- `o_x_waitrequest` = `i_p_waitrequest` when in GNT_x, else 1 (including IDLE and RD_x).
- `o_i_readdata`/`o_d_readdata` = `i_p_readdata` (broadcast); `o_x_readdata_valid` = `i_p_readdata_valid` only in GNT_x/RD_x of owner, else 0.
- Cache `i_p_readdata_valid` outside GNT/RD states is dropped.
- Only one transaction outstanding; no pipelining of back-to-back reads.

## Timing
- Reset (rst=0, async): state IDLE; all `o_p_*` 0; `o_x_waitrequest` 1; `o_x_readdata_valid` 0; `o_busy` 0; counters 0; RR pointer = instruction-last (data wins first tie). Reset mid-transaction abandons it; cache response after reset is dropped.
- Arbitration latency: request at cycle N → cache command visible cycle N+1 (registered grant, combinational forward).
- Minimum read: N+1 command, cache waitrequest=0 at N+1, valid at N+2, arbiter IDLE at N+3 edge, next grant command at N+4.
- Minimum write: command N+1 accepted, IDLE after N+1 edge, next command N+3.
- All outputs except readdata/valid/waitrequest pass-through are registered.

## Configuration
- `CACHE_ARB_RR_EN`: defined → round-robin on ties: port not granted last wins; pointer updates on every grant. Undefined → fixed priority, data port always wins; RR pointer logic absent.

## Test plan
- Reset: rst=0 mid-read (state RD_I) → within same cycle o_busy=0, o_i_waitrequest=1, o_p_read=0; counters 0 after release.
- Single instruction read addr 0x10, cache waitrequest 2 cycles then valid with 0x00500093 → o_i_readdata_valid=1 with 0x00500093, o_d_readdata_valid=0, cnt_grant_i=1.
- Data write addr 0x40, byte_en 4'b0011, data 0xDEADBEEF → o_p_write=1 with those values exactly one accepted cycle, o_p_byte_en=4'b0011, then IDLE.
- Simultaneous constant requests, macro undefined, 4 transactions → all 4 granted to data, cnt_grant_d=4, cnt_grant_i=0.
- Same stimulus with `CACHE_ARB_RR_EN` → grants D,I,D,I; cnt_grant_i=2, cnt_grant_d=2.
- Cache returns waitrequest=0 and readdata_valid=1 same cycle → owner valid pulses once, arbiter IDLE next edge, no RD state entered.

Source files
------------

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-master (instruction/data) arbiter for the cache CPU port
// Optional macro CACHE_ARB_RR_EN: round-robin tie break instead of fixed data-port priority.
module cache_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_i_addr,
  input  logic              i_i_read,
  output logic [DATA_W-1:0] o_i_readdata,
  output logic              o_i_readdata_valid,
  output logic              o_i_waitrequest,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [BE_W-1:0]   i_d_byte_en,
  input  logic [DATA_W-1:0] i_d_writedata,
  input  logic              i_d_read,
  input  logic              i_d_write,
  output logic [DATA_W-1:0] o_d_readdata,
  output logic              o_d_readdata_valid,
  output logic              o_d_waitrequest,
  output logic [ADDR_W-1:0] o_p_addr,
  output logic [BE_W-1:0]   o_p_byte_en,
  output logic [DATA_W-1:0] o_p_writedata,
  output logic              o_p_read,
  output logic              o_p_write,
  input  logic [DATA_W-1:0] i_p_readdata,
  input  logic              i_p_readdata_valid,
  input  logic              i_p_waitrequest,
  output logic              o_busy,
  output logic [31:0]       cnt_grant_i,
  output logic [31:0]       cnt_grant_d
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, RD_I, RD_D} state_t;

  state_t state, state_nxt;
  logic   i_req, d_req, any_req, pick_d;

  assign i_req   = i_i_read;
  assign d_req   = i_d_read | i_d_write;
  assign any_req = i_req | d_req;

`ifdef CACHE_ARB_RR_EN
  // last_i set means the instruction port owned the previous grant, so data wins the next tie
  logic last_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_i <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_i <= ~pick_d;
    end
  end

  assign pick_d = d_req & (~i_req | last_i);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt_grant_i <= '0;
      cnt_grant_d <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        if (pick_d) cnt_grant_d <= cnt_grant_d + 32'd1;
        else        cnt_grant_i <= cnt_grant_i + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = pick_d ? GNT_D : GNT_I;
      end
      GNT_I: begin
        // a withdrawn command abandons the grant without routing any response
        if (!i_req)                 state_nxt = IDLE;
        else if (!i_p_waitrequest)  state_nxt = i_p_readdata_valid ? IDLE : RD_I;
      end
      GNT_D: begin
        if (!d_req)                 state_nxt = IDLE;
        else if (!i_p_waitrequest)  state_nxt = (i_d_write || i_p_readdata_valid) ? IDLE : RD_D;
      end
      RD_I, RD_D: begin
        if (i_p_readdata_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_p_addr      = '0;
    o_p_byte_en   = '0;
    o_p_writedata = '0;
    o_p_read      = 1'b0;
    o_p_write     = 1'b0;
    case (state)
      GNT_I: begin
        o_p_addr    = i_i_addr;
        o_p_byte_en = '1;
        o_p_read    = i_i_read;
      end
      GNT_D: begin
        o_p_addr      = i_d_addr;
        o_p_byte_en   = i_d_byte_en;
        o_p_writedata = i_d_writedata;
        o_p_read      = i_d_read;
        o_p_write     = i_d_write;
      end
      default: ;
    endcase
  end

  assign o_i_waitrequest    = (state == GNT_I) ? i_p_waitrequest : 1'b1;
  assign o_d_waitrequest    = (state == GNT_D) ? i_p_waitrequest : 1'b1;
  assign o_i_readdata       = i_p_readdata;
  assign o_d_readdata       = i_p_readdata;
  assign o_i_readdata_valid = i_p_readdata_valid & ((state == GNT_I && i_req) || state == RD_I);
  assign o_d_readdata_valid = i_p_readdata_valid & ((state == GNT_D && d_req) || state == RD_D);
  assign o_busy             = (state != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
// Vector table of single transactions plus hand sequences for reset, withdrawal and ties.
module tb_cache_arbiter;

  localparam logic [24:0] TIE_I_ADDR = 25'h0000100;
  localparam logic [24:0] TIE_D_ADDR = 25'h0000200;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] i_addr;
  logic        i_read;
  logic [31:0] o_i_readdata;
  logic        o_i_readdata_valid, o_i_waitrequest;
  logic [24:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_read, d_write;
  logic [31:0] o_d_readdata;
  logic        o_d_readdata_valid, o_d_waitrequest;
  logic [24:0] o_p_addr;
  logic [3:0]  o_p_byte_en;
  logic [31:0] o_p_writedata;
  logic        o_p_read, o_p_write;
  logic [31:0] p_rdata;
  logic        p_valid, p_wait;
  logic        o_busy;
  logic [31:0] cnt_grant_i, cnt_grant_d;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_i_addr(i_addr), .i_i_read(i_read),
    .o_i_readdata(o_i_readdata), .o_i_readdata_valid(o_i_readdata_valid),
    .o_i_waitrequest(o_i_waitrequest),
    .i_d_addr(d_addr), .i_d_byte_en(d_be), .i_d_writedata(d_wdata),
    .i_d_read(d_read), .i_d_write(d_write),
    .o_d_readdata(o_d_readdata), .o_d_readdata_valid(o_d_readdata_valid),
    .o_d_waitrequest(o_d_waitrequest),
    .o_p_addr(o_p_addr), .o_p_byte_en(o_p_byte_en), .o_p_writedata(o_p_writedata),
    .o_p_read(o_p_read), .o_p_write(o_p_write),
    .i_p_readdata(p_rdata), .i_p_readdata_valid(p_valid), .i_p_waitrequest(p_wait),
    .o_busy(o_busy), .cnt_grant_i(cnt_grant_i), .cnt_grant_d(cnt_grant_d)
  );

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [24:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wait_n;
    int          vdelay;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ci = 0;
  logic [31:0] exp_cd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input logic is_d, input logic [31:0] data);
    rsp_t r;
    r.is_d = is_d;
    r.data = data;
    sb.push_back(r);
  endtask

  // every routed response must match the oldest expected one, on the right port
  always @(negedge clk) begin
    if (o_i_readdata_valid || o_d_readdata_valid) begin
      chk("rsp_one_port", o_i_readdata_valid & o_d_readdata_valid, 0);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {o_i_readdata_valid, o_d_readdata_valid}, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_port_d", o_d_readdata_valid, mon_e.is_d);
        chk("rsp_data", o_d_readdata_valid ? o_d_readdata : o_i_readdata, mon_e.data);
      end
    end
  end

  task automatic wait_cmd(output int n);
    n = 0;
    @(negedge clk);
    while (!(o_p_read || o_p_write) && n < 10) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drop_req();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    p_wait = 1'b1; p_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    logic same_cycle;
    same_cycle = !v.wr && v.vdelay == 0;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_addr = v.addr; d_be = v.be; d_wdata = v.wdata; d_read = !v.wr; d_write = v.wr;
    end else begin
      i_addr = v.addr; i_read = 1'b1; d_addr = 25'h0AAAA; d_be = v.be; d_wdata = v.wdata;
    end
    p_wait = (v.wait_n > 0);
    if (v.wait_n == 0 && same_cycle) begin
      p_valid = 1'b1; p_rdata = v.rdata; push_rsp(v.is_d, v.rdata);
    end
    wait_cmd(n);
    chk("grant_latency", n, 1);
    if (n >= 10) begin
      drop_req();
      return;
    end
    if (v.is_d) exp_cd++; else exp_ci++;
    chk("cmd_addr", o_p_addr, v.addr);
    chk("cmd_be", o_p_byte_en, v.exp_be);
    chk("cmd_wdata", o_p_writedata, v.exp_wdata);
    chk("cmd_write", o_p_write, v.wr);
    chk("cmd_read", o_p_read, !v.wr);
    chk("gnt_busy", o_busy, 1);
    chk("other_wait", v.is_d ? o_i_waitrequest : o_d_waitrequest, 1);
    chk("cnt_i", cnt_grant_i, exp_ci);
    chk("cnt_d", cnt_grant_d, exp_cd);
    if (v.wait_n > 0) begin
      chk("owner_wait_hi", v.is_d ? o_d_waitrequest : o_i_waitrequest, 1);
      repeat (v.wait_n) begin @(posedge clk); #1; end
      p_wait = 1'b0;
      if (same_cycle) begin
        p_valid = 1'b1; p_rdata = v.rdata; push_rsp(v.is_d, v.rdata);
      end
      #1;
      chk("cmd_held", v.wr ? o_p_write : o_p_read, 1);
    end
    chk("owner_wait_lo", v.is_d ? o_d_waitrequest : o_i_waitrequest, 0);
    @(posedge clk); #1;
    drop_req();
    if (!v.wr && v.vdelay == 1) begin
      p_valid = 1'b1; p_rdata = v.rdata; push_rsp(v.is_d, v.rdata);
    end
    @(negedge clk);
    chk("post_p_read", o_p_read, 0);
    chk("post_p_write", o_p_write, 0);
    if (v.wr || same_cycle) begin
      chk("post_idle", o_busy, 0);
    end else begin
      chk("rd_busy", o_busy, 1);
      chk("rd_owner_wait", v.is_d ? o_d_waitrequest : o_i_waitrequest, 1);
      if (v.vdelay > 1) begin
        repeat (v.vdelay - 1) begin @(posedge clk); #1; end
        p_valid = 1'b1; p_rdata = v.rdata; push_rsp(v.is_d, v.rdata);
      end
      @(posedge clk); #1;
      p_valid = 1'b0;
      @(negedge clk);
      chk("rd_done_idle", o_busy, 0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int   n;
    logic exp_d[4];

    //        is_d  wr   addr         be     wdata         wt dly rdata         exp_be exp_wdata
    vecs[0] = '{1'b0, 1'b0, 25'h0000010, 4'h0, 32'h0,        2, 1, 32'h00500093, 4'hF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 25'h0000040, 4'h3, 32'hDEADBEEF, 0, 0, 32'h0,        4'h3, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 25'h0000123, 4'hF, 32'h0,        0, 0, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 25'h1FFFFFF, 4'h6, 32'h13579BDF, 1, 3, 32'h12345678, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 25'h1000000, 4'hF, 32'hA5A55A5A, 3, 0, 32'h0,        4'hF, 32'hA5A55A5A};
    vecs[5] = '{1'b1, 1'b0, 25'h0000008, 4'h1, 32'h0,        0, 1, 32'h0BADCAFE, 4'h1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 25'h0000004, 4'h0, 32'h0,        0, 0, 32'hFFFFFFFF, 4'hF, 32'h0};

    rst = 1'b0;
    i_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0;
    drop_req();
    p_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_p_read", o_p_read, 0);
    chk("rst_p_write", o_p_write, 0);
    chk("rst_p_addr", o_p_addr, 0);
    chk("rst_i_wait", o_i_waitrequest, 1);
    chk("rst_d_wait", o_d_waitrequest, 1);
    chk("rst_cnt_i", cnt_grant_i, 0);
    chk("rst_cnt_d", cnt_grant_d, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) run_txn(vecs[k]);

    // data requester withdraws its read while the cache stalls
    @(posedge clk); #1;
    d_addr = 25'h77; d_read = 1'b1; d_write = 1'b0; p_wait = 1'b1; p_valid = 1'b0;
    wait_cmd(n);
    chk("wd_latency", n, 1);
    exp_cd++;
    @(posedge clk); #1;
    d_read = 1'b0; p_valid = 1'b1; p_rdata = 32'hBAD00001;
    #1;
    chk("wd_p_read", o_p_read, 0);
    chk("wd_d_valid", o_d_readdata_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wd_idle", o_busy, 0);
    chk("wd_cnt_d", cnt_grant_d, exp_cd);
    @(posedge clk); #1;
    drop_req();

    // asynchronous reset while waiting for read data
    @(posedge clk); #1;
    i_addr = 25'h20; i_read = 1'b1; p_wait = 1'b0; p_valid = 1'b0;
    wait_cmd(n);
    chk("rst_rd_latency", n, 1);
    @(posedge clk); #1;
    chk("rst_rd_busy", o_busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_i_wait", o_i_waitrequest, 1);
    chk("rst_mid_p_read", o_p_read, 0);
    chk("rst_mid_i_valid", o_i_readdata_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    drop_req();
    exp_ci = 0; exp_cd = 0;
    @(posedge clk); #1;
    chk("rst_rel_cnt_i", cnt_grant_i, 0);
    chk("rst_rel_cnt_d", cnt_grant_d, 0);
    p_valid = 1'b1; p_rdata = 32'hBAD00002;
    @(posedge clk); #1;
    p_valid = 1'b0;

    // both ports request continuously; cache completes each read in its grant cycle
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
`ifdef CACHE_ARB_RR_EN
      exp_d[t] = (t % 2 == 0);
`else
      exp_d[t] = 1'b1;
`endif
      push_rsp(exp_d[t], 32'hA0000000 + t);
      if (exp_d[t]) exp_cd++; else exp_ci++;
    end
    i_addr = TIE_I_ADDR; i_read = 1'b1;
    d_addr = TIE_D_ADDR; d_read = 1'b1; d_write = 1'b0;
    p_wait = 1'b0; p_valid = 1'b1; p_rdata = 32'hA0000000;
    for (int t = 0; t < 4; t++) begin
      wait_cmd(n);
      chk("tie_latency", n, 1);
      if (n >= 10) break;
      chk("tie_grant_d", o_p_addr == TIE_D_ADDR, exp_d[t]);
      @(posedge clk); #1;
      p_rdata = 32'hA0000000 + t + 1;
    end
    drop_req();
    chk("tie_cnt_i", cnt_grant_i, exp_ci);
    chk("tie_cnt_d", cnt_grant_d, exp_cd);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
